// File: rtl/arb_pkg.sv
// Shared constants, state encoding and the round-robin pick helper for the
// four-requester arbiter.
package arb_pkg;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned IDX_W = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } pick_t;

   // Searches last+1, last+2, ... with wrap; last itself is visited last.
   function automatic pick_t rr_pick(input logic [NREQ-1:0]  req,
                                     input logic [IDX_W-1:0] last);
      pick_t            p;
      logic [IDX_W-1:0] c;
      p = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         c = last + IDX_W'(i);
         if (!p.found && req[c]) begin
            p.found = 1'b1;
            p.idx   = c;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/decoder_2x4_en.sv
// 2-to-4 one-hot decoder with enable; output is all-zero when disabled.
module decoder_2x4_en
   import arb_pkg::*;
(
   input  logic [IDX_W-1:0] sel_i,
   input  logic             en_i,
   output logic [NREQ-1:0]  dout_o
);

   always_comb begin
      dout_o = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (en_i && (sel_i == IDX_W'(i))) begin
            dout_o[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with grant hold and a preemption
// timeout; the registered grant index is decoded to a one-hot grant.
module rr_arbiter_4
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [NREQ-1:0]       req,
   output logic [NREQ-1:0]       gnt,
   output logic [IDX_W-1:0]      gnt_idx,
   output logic                  gnt_vld,
   output logic                  preempt
);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
   logic             gnt_vld_q, gnt_vld_d;
   logic             preempt_q, preempt_d;

   logic [NREQ-1:0]  gnt_w;
   logic [NREQ-1:0]  others;
   pick_t            pick_all;
   pick_t            pick_oth;

   decoder_2x4_en u_dec (
      .sel_i  (gnt_idx_q),
      .en_i   (gnt_vld_q),
      .dout_o (gnt_w)
   );

   // gnt_w is the current grantee's one-hot while in GRANT, so masking it
   // off leaves only competing requesters.
   assign others   = req & ~gnt_w;
   assign pick_all = rr_pick(req, last_q);
   assign pick_oth = rr_pick(others, last_q);

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      hold_cnt_d = hold_cnt_q;
      gnt_idx_d  = gnt_idx_q;
      gnt_vld_d  = gnt_vld_q;
      preempt_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (en && pick_all.found) begin
               state_d    = GRANT;
               gnt_idx_d  = pick_all.idx;
               last_d     = pick_all.idx;
               gnt_vld_d  = 1'b1;
               hold_cnt_d = CNT_W'(1);
            end
         end
         GRANT: begin
            if (!req[gnt_idx_q]) begin
               if (en && pick_oth.found) begin
                  gnt_idx_d  = pick_oth.idx;
                  last_d     = pick_oth.idx;
                  hold_cnt_d = CNT_W'(1);
               end else begin
                  state_d   = IDLE;
                  gnt_vld_d = 1'b0;
               end
            end else if ((MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD)) &&
                         en && pick_oth.found) begin
               gnt_idx_d  = pick_oth.idx;
               last_d     = pick_oth.idx;
               hold_cnt_d = CNT_W'(1);
               preempt_d  = 1'b1;
            end else if (hold_cnt_q < CNT_W'(MAX_HOLD)) begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d   = IDLE;
            gnt_vld_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         last_q     <= IDX_W'(NREQ - 1);
         hold_cnt_q <= '0;
         gnt_idx_q  <= '0;
         gnt_vld_q  <= 1'b0;
         preempt_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         hold_cnt_q <= hold_cnt_d;
         gnt_idx_q  <= gnt_idx_d;
         gnt_vld_q  <= gnt_vld_d;
         preempt_q  <= preempt_d;
      end
   end

   assign gnt     = gnt_w;
   assign gnt_idx = gnt_idx_q;
   assign gnt_vld = gnt_vld_q;
   assign preempt = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_rr_arbiter_4;

   localparam int MAX_HOLD = 8;
   localparam int CNT_W    = 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       en    = 1'b0;
   logic [3:0] req   = 4'b0000;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_vld;
   logic       preempt;

   rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .req     (req),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld),
      .preempt (preempt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model: owner index, cycles held so far (unbounded), last winner.
   typedef struct {
      bit vld;
      int idx;
      int last;
      int held;
      bit pre;
   } model_t;

   model_t ms;

   function automatic int next_after(input logic [3:0] r, input int from);
      int j;
      for (int k = 1; k <= 4; k++) begin
         j = (from + k) % 4;
         if (r[j[1:0]]) return j;
      end
      return -1;
   endfunction

   function automatic model_t model_step(input model_t s, input logic [3:0] r, input bit e);
      model_t     n;
      logic [3:0] oth;
      int         j;
      n      = s;
      n.pre  = 1'b0;
      n.held = s.held + 1;
      if (!s.vld) begin
         if (e && r != 4'b0000) begin
            j      = next_after(r, s.last);
            n.vld  = 1'b1;
            n.idx  = j;
            n.last = j;
            n.held = 1;
         end
      end else begin
         oth = r;
         oth[s.idx[1:0]] = 1'b0;
         j = next_after(oth, s.idx);
         if (!r[s.idx[1:0]]) begin
            if (e && j >= 0) begin
               n.idx = j; n.last = j; n.held = 1;
            end else begin
               n.vld = 1'b0;
            end
         end else if (MAX_HOLD != 0 && s.held >= MAX_HOLD && e && j >= 0) begin
            n.idx = j; n.last = j; n.held = 1; n.pre = 1'b1;
         end
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ms <= '{vld: 1'b0, idx: 0, last: 3, held: 0, pre: 1'b0};
      end else begin
         ms <= model_step(ms, req, en);
      end
   end

   // Literal expectations set by the stimulus, checked at the next compare point.
   logic       lit_on     = 1'b0;
   logic [3:0] lit_gnt    = 4'b0000;
   logic       lit_pre    = 1'b0;
   logic       lit_cnt_on = 1'b0;
   logic [3:0] lit_cnt    = 4'd0;
   event       rst_probe;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
      end
   endtask

   initial begin
      logic [3:0] exp_gnt;
      forever begin
         @(negedge clk or rst_probe);
         exp_gnt = ms.vld ? (4'b0001 << ms.idx) : 4'b0000;
         check("gnt",     {4'b0, gnt},      {4'b0, exp_gnt});
         check("gnt_idx", {6'b0, gnt_idx},  8'(ms.idx));
         check("gnt_vld", {7'b0, gnt_vld},  {7'b0, ms.vld});
         check("preempt", {7'b0, preempt},  {7'b0, ms.pre});
         if (lit_on) begin
            check("lit_gnt", {4'b0, gnt},     {4'b0, lit_gnt});
            check("lit_pre", {7'b0, preempt}, {7'b0, lit_pre});
         end
         if (lit_cnt_on) check("hold_cnt", {4'b0, dut.hold_cnt_q}, {4'b0, lit_cnt});
      end
   end

   task automatic cyc(input logic [3:0] r, input logic e, input logic lo,
                      input logic [3:0] lg, input logic lp);
      @(negedge clk);
      #1;
      req = r; en = e; lit_on = lo; lit_gnt = lg; lit_pre = lp; lit_cnt_on = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b0; lit_on = 1'b0; req = 4'b0000; en = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1; lit_on = 1'b1; lit_gnt = 4'b0000; lit_pre = 1'b0;

      // Basic grant and release
      cyc(4'b0001, 1'b1, 1'b1, 4'b0001, 1'b0);
      cyc(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0);

      // Timeout rotation between two persistent requesters
      do_reset();
      for (int i = 0; i < 8; i++) cyc(4'b0011, 1'b1, 1'b1, 4'b0001, 1'b0);
      cyc(4'b0011, 1'b1, 1'b1, 4'b0010, 1'b1);
      for (int i = 0; i < 7; i++) cyc(4'b0011, 1'b1, 1'b1, 4'b0010, 1'b0);
      cyc(4'b0011, 1'b1, 1'b1, 4'b0001, 1'b1);
      cyc(4'b0011, 1'b1, 1'b1, 4'b0001, 1'b0);

      // Fairness: each grantee releases for one cycle, no bubbles
      do_reset();
      cyc(4'b1111, 1'b1, 1'b1, 4'b0001, 1'b0);
      for (int k = 0; k < 4; k++) begin
         cyc(4'b1111 & ~(4'b0001 << k), 1'b1, 1'b1, 4'b0001 << ((k + 1) % 4), 1'b0);
      end

      // Lone holder keeps the grant; counter saturates
      for (int i = 0; i < 20; i++) cyc(4'b0100, 1'b1, 1'b1, 4'b0100, 1'b0);
      lit_cnt_on = 1'b1; lit_cnt = 4'd8;

      // Disable while granted
      cyc(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0);
      cyc(4'b0010, 1'b1, 1'b1, 4'b0010, 1'b0);
      for (int i = 0; i < 3; i++) cyc(4'b0110, 1'b0, 1'b1, 4'b0010, 1'b0);
      for (int i = 0; i < 4; i++) cyc(4'b0100, 1'b0, 1'b1, 4'b0000, 1'b0);
      cyc(4'b0100, 1'b1, 1'b1, 4'b0100, 1'b0);
      cyc(4'b0100, 1'b1, 1'b1, 4'b0100, 1'b0);

      // Asynchronous reset mid-grant
      @(posedge clk);
      #2;
      rst_n = 1'b0; lit_on = 1'b1; lit_gnt = 4'b0000; lit_pre = 1'b0;
      #1;
      -> rst_probe;
      req = 4'b1000;
      @(negedge clk);
      #1;
      rst_n = 1'b1; en = 1'b1; lit_gnt = 4'b1000;
      cyc(4'b1000, 1'b1, 1'b1, 4'b1000, 1'b0);

      // Randomized traffic against the model
      lit_on = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         #1;
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
         en = ($urandom_range(0, 7) != 0);
      end

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
